// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle base ops plus optional N-cycle iterative MUL/MULHU/DIVU/REMU.
// Define SEQ_ALU_MULDIV_EN to build the iterative multiply/divide unit; otherwise codes 8-11 are illegal.
module seq_alu #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   sel,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_result,
    output logic         sign_flag,
    output logic         zero_flag,
    output logic         dz_flag,
    output logic         illegal_op
);
    localparam int SW = $clog2(N);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] DONE = 2'd2;
`ifdef SEQ_ALU_MULDIV_EN
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [SW:0] CNT_INIT = (SW+1)'(N);
    localparam logic [SW:0] CNT_ONE  = (SW+1)'(1);
`endif

    logic [1:0]   state_reg;
    logic [N-1:0] result_reg;
    logic         sign_reg;
    logic         zero_reg;
    logic         illegal_reg;
    logic [N-1:0] base_result;
    logic         base_legal;

    always_comb begin
        base_result = '0;
        base_legal  = 1'b1;
        case (sel)
            4'd0:    base_result = A + B;
            4'd1:    base_result = A << B[SW-1:0];
            4'd2:    base_result = A - B;
            4'd3:    base_result = {{(N-1){1'b0}}, (A < B)};
            4'd4:    base_result = A ^ B;
            4'd5:    base_result = A >> B[SW-1:0];
            4'd6:    base_result = A | B;
            4'd7:    base_result = A & B;
            default: base_legal  = 1'b0;
        endcase
    end

`ifdef SEQ_ALU_MULDIV_EN
    // p_reg holds {hi, lo}: product accumulator for multiply, {remainder, quotient} for divide.
    logic [2*N-1:0] p_reg;
    logic [2*N-1:0] p_next;
    logic [N-1:0]   b_reg;
    logic [1:0]     op_reg;
    logic [SW:0]    cnt_reg;
    logic           dz_reg;
    logic [N:0]     mul_sum;
    logic [N:0]     div_shift;
    logic [N-1:0]   div_diff;
    logic [N-1:0]   muldiv_result;

    always_comb begin
        p_next    = p_reg;
        mul_sum   = {1'b0, p_reg[2*N-1:N]} + (p_reg[0] ? {1'b0, b_reg} : {(N+1){1'b0}});
        div_shift = p_reg[2*N-1:N-1];
        div_diff  = div_shift[N-1:0] - b_reg;
        if (!op_reg[1]) begin
            p_next = {mul_sum, p_reg[N-1:1]};
        end else if (div_shift >= {1'b0, b_reg}) begin
            p_next = {div_diff, p_reg[N-2:0], 1'b1};
        end else begin
            p_next = {div_shift[N-1:0], p_reg[N-2:0], 1'b0};
        end
        // With B == 0 every trial subtract succeeds, yielding all-ones quotient and remainder A.
        muldiv_result = op_reg[0] ? p_next[2*N-1:N] : p_next[N-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            result_reg  <= '0;
            sign_reg    <= 1'b0;
            zero_reg    <= 1'b0;
            illegal_reg <= 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
            dz_reg      <= 1'b0;
            p_reg       <= '0;
            b_reg       <= '0;
            op_reg      <= '0;
            cnt_reg     <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
`ifdef SEQ_ALU_MULDIV_EN
                        if (sel[3:2] == 2'b10) begin
                            state_reg <= BUSY;
                            p_reg     <= {{N{1'b0}}, A};
                            b_reg     <= B;
                            op_reg    <= sel[1:0];
                            cnt_reg   <= CNT_INIT;
                        end else
`endif
                        begin
                            state_reg   <= DONE;
                            result_reg  <= base_result;
                            sign_reg    <= base_result[N-1];
                            zero_reg    <= (base_result == '0);
                            illegal_reg <= ~base_legal;
`ifdef SEQ_ALU_MULDIV_EN
                            dz_reg      <= 1'b0;
`endif
                        end
                    end
                end
`ifdef SEQ_ALU_MULDIV_EN
                BUSY: begin
                    p_reg   <= p_next;
                    cnt_reg <= cnt_reg - CNT_ONE;
                    if (cnt_reg == CNT_ONE) begin
                        state_reg   <= DONE;
                        result_reg  <= muldiv_result;
                        sign_reg    <= muldiv_result[N-1];
                        zero_reg    <= (muldiv_result == '0);
                        illegal_reg <= 1'b0;
                        dz_reg      <= op_reg[1] && (b_reg == '0);
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE);
    assign out_valid  = (state_reg == DONE);
    assign alu_result = result_reg;
    assign sign_flag  = sign_reg;
    assign zero_flag  = zero_reg;
    assign illegal_op = illegal_reg;
`ifdef SEQ_ALU_MULDIV_EN
    assign dz_flag    = dz_reg;
`else
    assign dz_flag    = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (N=32); expectations come from an arithmetic reference model.
module tb_seq_alu;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_result;
    logic        sign_flag;
    logic        zero_flag;
    logic        dz_flag;
    logic        illegal_op;

    int checks = 0;
    int fails  = 0;

    seq_alu #(.N(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result), .sign_flag(sign_flag), .zero_flag(zero_flag),
        .dz_flag(dz_flag), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        dz;
        logic        il;
        int          lat;
    } vec_t;

    // Reference model: plain 64-bit arithmetic from the operation table.
    function automatic void model(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic dz, output logic il,
                                  output int lat);
        logic [63:0] prod;
        prod = {32'd0, a} * {32'd0, b};
        r = 32'd0; dz = 1'b0; il = 1'b0; lat = 1;
        case (s)
            4'd0: r = a + b;
            4'd1: r = a << b[4:0];
            4'd2: r = a - b;
            4'd3: r = (a < b) ? 32'd1 : 32'd0;
            4'd4: r = a ^ b;
            4'd5: r = a >> b[4:0];
            4'd6: r = a | b;
            4'd7: r = a & b;
`ifdef SEQ_ALU_MULDIV_EN
            4'd8:  begin r = prod[31:0];  lat = 33; end
            4'd9:  begin r = prod[63:32]; lat = 33; end
            4'd10: begin lat = 33; if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end else r = a / b; end
            4'd11: begin lat = 33; if (b == 0) begin r = a; dz = 1'b1; end else r = a % b; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Drives one request, measures cycles from accept to out_valid, then consumes the result.
    task automatic run_op(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b,
                          input logic early,
                          output logic [31:0] r, output logic sg, output logic zr,
                          output logic dz, output logic il, output int lat,
                          output logic post_ir, output logic post_ov);
        @(negedge clk);
        sel = s; A = a; B = b; in_valid = 1'b1; out_ready = early;
        @(posedge clk); #1;
        in_valid = 1'($urandom_range(0, 1));
        sel = 4'($urandom); A = $urandom; B = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        r = alu_result; sg = sign_flag; zr = zero_flag; dz = dz_flag; il = illegal_op;
        out_ready = 1'b1;
        @(posedge clk); #1;
        post_ir = in_ready; post_ov = out_valid;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sel = 4'd0; A = 32'd0; B = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({alu_result, sign_flag, zero_flag, dz_flag, illegal_op} !== 36'd0) begin
            fails++; $display("FAIL reset_outputs: got result=%h s=%b z=%b dz=%b il=%b expected all 0",
                              alu_result, sign_flag, zero_flag, dz_flag, illegal_op);
        end
    endtask

    task automatic test_directed;
        vec_t v[$];
        logic [31:0] r; logic sg, zr, dz, il, pir, pov; int lat;
        v.push_back('{4'd0, 32'd512, 32'd512, 32'd1024, 1'b0, 1'b0, 1});
        v.push_back('{4'd2, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1});
        v.push_back('{4'd2, 32'd1024, 32'd2048, 32'hFFFFFC00, 1'b0, 1'b0, 1});
        v.push_back('{4'd1, 32'd31, 32'd4, 32'd496, 1'b0, 1'b0, 1});
        v.push_back('{4'd1, 32'd31, 32'd28, 32'hF0000000, 1'b0, 1'b0, 1});
        v.push_back('{4'd5, 32'h80000000, 32'hFFFFFFE1, 32'h40000000, 1'b0, 1'b0, 1});
        v.push_back('{4'd3, 32'd3, 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0, 1});
        v.push_back('{4'd3, 32'hFFFFFFFF, 32'd3, 32'd0, 1'b0, 1'b0, 1});
        v.push_back('{4'd13, 32'd7, 32'd9, 32'd0, 1'b0, 1'b1, 1});
`ifdef SEQ_ALU_MULDIV_EN
        v.push_back('{4'd8, 32'd6, 32'd5, 32'd30, 1'b0, 1'b0, 33});
        v.push_back('{4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33});
        v.push_back('{4'd10, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 33});
        v.push_back('{4'd11, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 33});
        v.push_back('{4'd10, 32'd9, 32'd0, 32'hFFFFFFFF, 1'b1, 1'b0, 33});
        v.push_back('{4'd11, 32'd9, 32'd0, 32'd9, 1'b1, 1'b0, 33});
`else
        v.push_back('{4'd8, 32'd6, 32'd5, 32'd0, 1'b0, 1'b1, 1});
        v.push_back('{4'd10, 32'd9, 32'd0, 32'd0, 1'b0, 1'b1, 1});
`endif
        foreach (v[i]) begin
            run_op(v[i].s, v[i].a, v[i].b, 1'b0, r, sg, zr, dz, il, lat, pir, pov);
            $display("directed sel=%0d A=%h B=%h -> result=%h lat=%0d", v[i].s, v[i].a, v[i].b, r, lat);
            checks++; if (r !== v[i].r) begin fails++; $display("FAIL dir_result[%0d]: got %h expected %h", i, r, v[i].r); end
            checks++; if (sg !== v[i].r[31]) begin fails++; $display("FAIL dir_sign[%0d]: got %b expected %b", i, sg, v[i].r[31]); end
            checks++; if (zr !== (v[i].r == 32'd0)) begin fails++; $display("FAIL dir_zero[%0d]: got %b expected %b", i, zr, (v[i].r == 32'd0)); end
            checks++; if (dz !== v[i].dz) begin fails++; $display("FAIL dir_dz[%0d]: got %b expected %b", i, dz, v[i].dz); end
            checks++; if (il !== v[i].il) begin fails++; $display("FAIL dir_illegal[%0d]: got %b expected %b", i, il, v[i].il); end
            checks++; if (lat !== v[i].lat) begin fails++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat); end
            checks++; if ({pir, pov} !== 2'b10) begin fails++; $display("FAIL dir_consume[%0d]: got in_ready=%b out_valid=%b expected 1 0", i, pir, pov); end
        end
    endtask

    task automatic test_random;
        logic [31:0] a, b, r, er; logic sg, zr, dz, il, edz, eil, pir, pov; logic [3:0] s; int lat, elat;
        for (int i = 0; i < 40; i++) begin
            s = 4'($urandom_range(0, 15));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 40));
                default: b = $urandom;
            endcase
            model(s, a, b, er, edz, eil, elat);
            run_op(s, a, b, 1'($urandom_range(0, 1)), r, sg, zr, dz, il, lat, pir, pov);
            $display("random sel=%0d A=%h B=%h -> result=%h dz=%b il=%b lat=%0d", s, a, b, r, dz, il, lat);
            checks++;
            if ({r, sg, zr, dz, il} !== {er, er[31], (er == 32'd0), edz, eil} || lat !== elat || {pir, pov} !== 2'b10) begin
                fails++;
                $display("FAIL rand[%0d]: got r=%h s=%b z=%b dz=%b il=%b lat=%0d ir=%b ov=%b expected r=%h s=%b z=%b dz=%b il=%b lat=%0d ir=1 ov=0",
                         i, r, sg, zr, dz, il, lat, pir, pov, er, er[31], (er == 32'd0), edz, eil, elat);
            end
        end
    endtask

    task automatic test_hold;
        logic [3:0] s; logic [31:0] er; logic edz, eil; int elat, lat; logic bad;
`ifdef SEQ_ALU_MULDIV_EN
        s = 4'd8;
`else
        s = 4'd0;
`endif
        model(s, 32'd6, 32'd5, er, edz, eil, elat);
        @(negedge clk);
        sel = s; A = 32'd6; B = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== elat) begin fails++; $display("FAIL hold_latency: got %0d expected %0d", lat, elat); end
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; sel = 4'($urandom_range(0, 7)); A = $urandom; B = $urandom;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_result !== er || sign_flag !== er[31] ||
                zero_flag !== (er == 32'd0) || dz_flag !== 1'b0 || illegal_op !== 1'b0) bad = 1'b1;
        end
        in_valid = 1'b0;
        $display("hold sel=%0d result=%h held 10 cycles", s, alu_result);
        checks++; if (bad !== 1'b0) begin fails++; $display("FAIL hold_stable: got unstable outputs (last result=%h ov=%b ir=%b) expected %h held", alu_result, out_valid, in_ready, er); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL hold_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, r, er; logic sg, zr, dz, il, edz, eil, pir, pov; logic [3:0] s; int lat, elat;
        for (int i = 0; i < 6; i++) begin
            s = 4'($urandom_range(0, 7)); a = $urandom; b = $urandom;
            model(s, a, b, er, edz, eil, elat);
            run_op(s, a, b, 1'b1, r, sg, zr, dz, il, lat, pir, pov);
            $display("b2b sel=%0d A=%h B=%h -> result=%h lat=%0d", s, a, b, r, lat);
            checks++;
            if (r !== er || lat !== 1 || {pir, pov} !== 2'b10) begin
                fails++;
                $display("FAIL b2b[%0d]: got r=%h lat=%0d ir=%b ov=%b expected r=%h lat=1 ir=1 ov=0", i, r, lat, pir, pov, er);
            end
        end
    endtask

    task automatic test_reset_abort;
        logic [31:0] r; logic sg, zr, dz, il, pir, pov, seen; int lat;
        @(negedge clk);
`ifdef SEQ_ALU_MULDIV_EN
        sel = 4'd10; A = 32'd100; B = 32'd7;
`else
        sel = 4'd0; A = 32'd100; B = 32'd7;
`endif
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({in_ready, out_valid} !== 2'b10) begin fails++; $display("FAIL abort_state: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid); end
        checks++; if ({alu_result, sign_flag, zero_flag, dz_flag, illegal_op} !== 36'd0) begin
            fails++; $display("FAIL abort_outputs: got result=%h expected 0 with flags 0", alu_result);
        end
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_result: got out_valid=1 expected 0"); end
        run_op(4'd0, 32'd1, 32'd1, 1'b0, r, sg, zr, dz, il, lat, pir, pov);
        $display("after abort ADD 1+1 -> result=%h lat=%0d", r, lat);
        checks++; if (r !== 32'd2 || lat !== 1) begin fails++; $display("FAIL abort_followup: got r=%h lat=%0d expected 2 lat 1", r, lat); end
        // Reset wins over a handshake in the same cycle.
        @(negedge clk);
        sel = 4'd0; A = 32'd3; B = 32'd4; in_valid = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 3; c++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
        $display("reset-priority handshake -> out_valid seen=%b in_ready=%b", seen, in_ready);
        checks++; if ({seen, in_ready} !== 2'b01) begin fails++; $display("FAIL rst_priority: got seen=%b in_ready=%b expected 0 1", seen, in_ready); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_hold();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
# seq_alu

Registered, handshaked successor to the single-cycle datapath ALU. It executes the eight base ALU operations in one cycle and adds iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU), taking N cycles each. It sits between the register-file read stage and writeback in the multi-cycle core. Operands are accepted on a valid/ready handshake, and a registered result with flags is held until the consumer takes it.

## Interface
- N, default 32: operand/result width; must be ≥ 4 and a power of two.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept; high only in IDLE.
- sel  input  4  operation code.
- A, B  input  N  operands.
- out_valid  output  1  result valid; held until out_ready.
- out_ready  input  1  consumer accepts result.
- alu_result  output  N  registered result.
- sign_flag  output  1  alu_result[N-1].
- zero_flag  output  1  alu_result == 0.
- dz_flag  output  1  DIVU/REMU with B == 0.
- illegal_op  output  1  sel not implemented in this build.

## Operation
- sel codes:
  - 0 ADD: A+B, mod 2^N.
  - 1 SHL: A << B[log2N-1:0].
  - 2 SUB: A−B, mod 2^N.
  - 3 SLTU: {0…,A<B} unsigned.
  - 4 XOR.
  - 5 SHR: logical, A >> B[log2N-1:0].
  - 6 OR.
  - 7 AND.
  - 8 MUL: low N bits of A*B.
  - 9 MULHU: high N bits of the unsigned 2N product.
  - 10 DIVU: A/B.
  - 11 REMU: A%B.
  - 12–15: illegal.
- Shift amounts use only the low log2(N) bits of B. Upper bits are ignored.
- FSM states:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) latches sel/A/B. Codes 0–7 and illegal codes go to DONE. Codes 8–11 go to BUSY with the counter loaded to N.
  - BUSY: one shift-add (MUL/MULHU) or one restoring-divide step (DIVU/REMU) per cycle. The counter decrements each cycle. Exit to DONE after the Nth step.
  - DONE: out_valid=1. alu_result and all flags are stable. When out_ready=1, go to IDLE.
- Divide by zero: DIVU returns all-ones and REMU returns A, with dz_flag=1. The iteration still runs the full N cycles, so latency is constant.
- Illegal sel: alu_result=0, zero_flag=1, illegal_op=1. The op completes like a single-cycle op.
- Flags are computed from the final registered result only. They are never taken from partial iterative state.
- Inputs are ignored outside IDLE. Operand changes during BUSY or DONE have no effect.

## Timing
- Handshake at edge k:
  - Codes 0–7 and illegal: out_valid=1 from edge k+1.
  - Codes 8–11: BUSY for edges k+1…k+N, out_valid=1 from edge k+N+1.
- Result consumed at edge m (out_valid & out_ready): out_valid=0 and in_ready=1 from edge m+1. No accept happens in the DONE cycle.
- Best-case throughput is one op per 2 cycles. MUL/DIV throughput is one op per N+2 cycles.
- out_ready held high in advance completes the transfer in the first DONE cycle.
- Reset values: state=IDLE, in_ready=1 during reset-deasserted IDLE, out_valid=0, alu_result=0, sign_flag=0, zero_flag=0, dz_flag=0, illegal_op=0.
- rst asserted in any state, including mid-BUSY, aborts the operation. The block is in IDLE with reset values at the next edge, and no partial result is ever presented.
- rst takes priority over a simultaneous handshake.

## Configuration
- Macro: SEQ_ALU_MULDIV_EN.
  - Defined: codes 8–11 are implemented as described, and the BUSY state, counter and 2N-bit iteration registers are present.
  - Undefined: BUSY logic is not synthesised. Codes 8–11 are treated as illegal (1-cycle, result 0, illegal_op=1), and dz_flag is tied to 0.

## Test plan
- Reset: assert rst for 2 cycles, then release -> in_ready=1, out_valid=0, all outputs 0.
- ADD 512+512 -> 1024 one cycle after accept. SUB 5−5 -> 0 with zero_flag=1. SUB 1024−2048 -> 0xFFFFFC00 with sign_flag=1. SHL 31<<4 with N=32 -> 496. SHL 31<<28 -> 0xF0000000 with sign_flag=1.
- With SEQ_ALU_MULDIV_EN, N=32:
  - MUL 6*5 -> 30, out_valid exactly 33 cycles after accept.
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
  - DIVU 100/7 -> 14. REMU 100%7 -> 2.
- DIVU 9/0 -> 0xFFFFFFFF with dz_flag=1. REMU 9/0 -> 9 with dz_flag=1. Latency is still 33 cycles.
- Hold out_ready=0 for 10 cycles after MUL completes -> result and flags stable, in_ready=0, new in_valid ignored. Raise out_ready -> in_ready=1 next cycle.
- Assert rst at BUSY cycle 15 of DIVU -> IDLE next edge, out_valid never rises. A following ADD 1+1 -> 2 with normal 1-cycle latency.
- sel=13, or sel=8 without SEQ_ALU_MULDIV_EN -> illegal_op=1, result 0, zero_flag=1, 1-cycle latency.
